// File: rtl/pwc_pkg.sv
// Shared definitions for the pulse width classifier: FSM state encoding and
// the unsigned absolute-difference helper used for classification.
package pwc_pkg;

    // Widest TIMER_W supported. Callers zero-extend their operands to this width.
    localparam int PWC_DIFF_W = 32;

    typedef enum logic {
        PWC_LOW  = 1'b0,
        PWC_HIGH = 1'b1
    } pwc_state_e;

    // |a - b| on unsigned operands. The larger value is always the minuend, so
    // the result cannot wrap.
    function automatic logic [PWC_DIFF_W-1:0] pwc_abs_diff(
        input logic [PWC_DIFF_W-1:0] a,
        input logic [PWC_DIFF_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/pwc_output_slot.sv
// One-entry valid/ready holding register for classifier results.
// A result offered while the slot is full and not draining is dropped, the
// held result is kept, and a sticky overflow flag is raised.
module pwc_output_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] width_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic             bit_o,
    output logic [WIDTH-1:0] width_o,
    output logic             overflow_o
);

    logic             valid_q;
    logic             bit_q;
    logic [WIDTH-1:0] width_q;
    logic             overflow_q;

    // The slot can take a new result when it is empty or is handing its
    // current result over on this same edge.
    logic slot_free;
    assign slot_free = !valid_q || ready_i;

    // Load, drain and overflow tracking for the holding register.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q    <= 1'b0;
            bit_q      <= 1'b0;
            width_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register in this
            // block sees the pre-edge values of the others, like real flops.
            if (load_i && slot_free) begin
                valid_q <= 1'b1;
                bit_q   <= bit_i;
                width_q <= width_i;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
            if (load_i && !slot_free) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign valid_o    = valid_q;
    assign bit_o      = bit_q;
    assign width_o    = width_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/pulse_width_classifier.sv
// Pulse width classifier: times each high pulse on digital_in, learns the
// shortest and longest accepted widths, and reports each pulse as short (0)
// or long (1) through a one-entry valid/ready output slot.
// Optional: define PWC_INPUT_SYNC_EN to pass digital_in through a 2-flop
// synchroniser before sampling (edge timing shifts by 2 cycles).
module pulse_width_classifier
    import pwc_pkg::*;
#(
    parameter int TIMER_W   = 8,
    parameter int MIN_PULSE = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               digital_in,
    input  logic               clear_training,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_bit,
    output logic [TIMER_W-1:0] out_width,
    output logic [TIMER_W-1:0] min_width,
    output logic [TIMER_W-1:0] max_width,
    output logic               trained,
    output logic               timeout,
    output logic               overflow
);

    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
    localparam logic [TIMER_W-1:0] MIN_W     = TIMER_W'(MIN_PULSE);

    logic s;
    logic prev_q;

`ifdef PWC_INPUT_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= digital_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = digital_in;
`endif

    logic rise;
    logic fall;
    assign rise = s && !prev_q;
    assign fall = !s && prev_q;

    pwc_state_e         state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic               timeout_q;

    // Saturating increment; holds at TIMER_MAX once reached.
    assign timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;

    // Pulse FSM: LOW waits for a rising edge, HIGH counts until the falling
    // edge. The timer and sticky timeout are owned here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= PWC_LOW;
            prev_q    <= 1'b0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            prev_q <= s;
            case (state_q)
                PWC_LOW: begin
                    if (rise) begin
                        state_q   <= PWC_HIGH;
                        timer_q   <= TIMER_W'(1);
                        timeout_q <= 1'b0;
                    end
                end
                PWC_HIGH: begin
                    if (fall) begin
                        state_q <= PWC_LOW;
                    end else if (s) begin
                        timer_q <= timer_d;
                        if (timer_d == TIMER_MAX) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= PWC_LOW;
            endcase
        end
    end

    logic [TIMER_W-1:0] min_q;
    logic [TIMER_W-1:0] max_q;

    logic                  accept;
    logic                  class_bit;
    logic [PWC_DIFF_W-1:0] d_min;
    logic [PWC_DIFF_W-1:0] d_max;

    // Evaluate the pulse at its falling edge against the pre-update min/max.
    // Glitches and timed-out pulses are discarded entirely.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        accept    = 1'b0;
        d_min     = pwc_abs_diff(PWC_DIFF_W'(timer_q), PWC_DIFF_W'(min_q));
        d_max     = pwc_abs_diff(PWC_DIFF_W'(timer_q), PWC_DIFF_W'(max_q));
        class_bit = !(d_min < d_max);
        if (state_q == PWC_HIGH && fall && !timeout_q && timer_q >= MIN_W) begin
            accept = 1'b1;
        end
    end

    // Adaptive min/max learning; a training clear takes priority over any
    // update from a coincident evaluation.
    always_ff @(posedge clock) begin
        if (reset || clear_training) begin
            min_q <= '1;
            max_q <= '0;
        end else if (accept) begin
            if (timer_q < min_q) min_q <= timer_q;
            if (timer_q > max_q) max_q <= timer_q;
        end
    end

    pwc_output_slot #(
        .WIDTH(TIMER_W)
    ) u_output_slot (
        .clock      (clock),
        .reset      (reset),
        .load_i     (accept),
        .bit_i      (class_bit),
        .width_i    (timer_q),
        .ready_i    (out_ready),
        .valid_o    (out_valid),
        .bit_o      (out_bit),
        .width_o    (out_width),
        .overflow_o (overflow)
    );

    assign min_width = min_q;
    assign max_width = max_q;
    assign trained   = (min_q < max_q);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pulse_width_classifier.sv
// Directed self-checking bench for pulse_width_classifier (TIMER_W=8,
// MIN_PULSE=2). Inputs change 1 ns after a rising clock edge and outputs are
// sampled at the same point, so each tick() is one sampled edge.
module tb_pulse_width_classifier;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       digital_in = 1'b0;
    logic       clear_training = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_bit;
    logic [7:0] out_width;
    logic [7:0] min_width;
    logic [7:0] max_width;
    logic       trained;
    logic       timeout;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_width_classifier #(
        .TIMER_W   (8),
        .MIN_PULSE (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .digital_in     (digital_in),
        .clear_training (clear_training),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_bit        (out_bit),
        .out_width      (out_width),
        .min_width      (min_width),
        .max_width      (max_width),
        .trained        (trained),
        .timeout        (timeout),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive a high phase of w sampled edges, leaving the input low so the
    // next tick() samples the falling edge.
    task automatic high_phase(input int w);
        digital_in = 1'b1;
        repeat (w) tick();
        digital_in = 1'b0;
    endtask

    // Full pulse with latency check: no result before the falling-edge
    // sample, a result with the expected bit and width right after it.
    task automatic pulse_and_check(input string tag, input int w, input logic exp_bit);
        high_phase(w);
        check({tag, "_pre_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_bit"}, 32'(out_bit), 32'(exp_bit));
        check({tag, "_width"}, 32'(out_width), 32'(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        tick();
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_min",      32'(min_width), 32'd255);
        check("rst_max",      32'(max_width), 32'd0);
        check("rst_trained",  32'(trained),   32'd0);
        check("rst_timeout",  32'(timeout),   32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        idle(2);

        // Learning: 3 -> 1 (252 vs 3), 9 -> 1 (tie 6/6), 3 -> 0 (0 vs 6), 10 -> 1 (7 vs 1)
        pulse_and_check("learn3a", 3, 1'b1);
        idle(4);
        check("learn3a_drained", 32'(out_valid), 32'd0);
        pulse_and_check("learn9", 9, 1'b1);
        idle(4);
        pulse_and_check("learn3b", 3, 1'b0);
        idle(4);
        pulse_and_check("learn10", 10, 1'b1);
        idle(4);
        check("learn_min",     32'(min_width), 32'd3);
        check("learn_max",     32'(max_width), 32'd10);
        check("learn_trained", 32'(trained),   32'd1);

        // Glitch of width 1 is discarded
        high_phase(1);
        tick();
        check("glitch_valid", 32'(out_valid), 32'd0);
        tick();
        check("glitch_valid2", 32'(out_valid), 32'd0);
        check("glitch_min",   32'(min_width), 32'd3);
        check("glitch_max",   32'(max_width), 32'd10);
        idle(3);

        // Timeout: timer reaches 255 on the 255th high edge
        digital_in = 1'b1;
        idle(254);
        check("to_before", 32'(timeout), 32'd0);
        tick();
        check("to_set", 32'(timeout), 32'd1);
        idle(45);
        digital_in = 1'b0;
        tick();
        check("to_fall_valid", 32'(out_valid), 32'd0);
        check("to_sticky",     32'(timeout),   32'd1);
        tick();
        check("to_fall_valid2", 32'(out_valid), 32'd0);
        check("to_min", 32'(min_width), 32'd3);
        check("to_max", 32'(max_width), 32'd10);
        idle(2);
        digital_in = 1'b1;
        tick();
        check("to_cleared", 32'(timeout), 32'd0);
        idle(2);
        digital_in = 1'b0;
        tick();
        check("to_next_valid", 32'(out_valid), 32'd1);
        check("to_next_bit",   32'(out_bit),   32'd0);
        check("to_next_width", 32'(out_width), 32'd3);
        idle(4);

        // Backpressure: 4 held, 8 dropped with overflow
        out_ready = 1'b0;
        high_phase(4);
        tick();
        check("bp4_valid", 32'(out_valid), 32'd1);
        check("bp4_bit",   32'(out_bit),   32'd0);
        check("bp4_width", 32'(out_width), 32'd4);
        check("bp4_ovf",   32'(overflow),  32'd0);
        idle(4);
        high_phase(8);
        tick();
        check("bp8_valid", 32'(out_valid), 32'd1);
        check("bp8_width", 32'(out_width), 32'd4);
        check("bp8_bit",   32'(out_bit),   32'd0);
        check("bp8_ovf",   32'(overflow),  32'd1);
        idle(2);
        check("bp_hold_width", 32'(out_width), 32'd4);
        out_ready = 1'b1;
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_ovf_sticky", 32'(overflow), 32'd1);
        idle(3);

        // Standalone training clear
        clear_training = 1'b1;
        tick();
        clear_training = 1'b0;
        check("clr_min",     32'(min_width), 32'd255);
        check("clr_max",     32'(max_width), 32'd0);
        check("clr_trained", 32'(trained),   32'd0);
        idle(2);
        pulse_and_check("retrain3", 3, 1'b1);
        idle(4);
        pulse_and_check("retrain9", 9, 1'b1);
        idle(4);
        check("retrain_min", 32'(min_width), 32'd3);
        check("retrain_max", 32'(max_width), 32'd9);

        // Clear coincident with falling edge of width 5: classified with
        // old min/max (2 vs 4 -> 0), learning update suppressed
        high_phase(5);
        clear_training = 1'b1;
        tick();
        clear_training = 1'b0;
        check("clrfall_valid",   32'(out_valid), 32'd1);
        check("clrfall_bit",     32'(out_bit),   32'd0);
        check("clrfall_width",   32'(out_width), 32'd5);
        check("clrfall_min",     32'(min_width), 32'd255);
        check("clrfall_max",     32'(max_width), 32'd0);
        check("clrfall_trained", 32'(trained),   32'd0);
        idle(3);

        // Reset in the middle of a pulse: nothing reported afterwards
        digital_in = 1'b1;
        idle(4);
        reset = 1'b1;
        tick();
        digital_in = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_valid", 32'(out_valid), 32'd0);
        end
        check("midrst_ovf",     32'(overflow),  32'd0);
        check("midrst_min",     32'(min_width), 32'd255);
        check("midrst_timeout", 32'(timeout),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
